// File: rtl/death_sequencer.sv
// Death sequencer: detects Mario's death (enemy side contact or falling off screen),
// holds kill for the death animation, then respawns with invulnerability or latches game over.
module death_sequencer #(
  parameter int DEATH_FRAMES  = 60,
  parameter int INVULN_FRAMES = 120,
  parameter int FLOOR_Y       = 470,
  parameter int Y_WIDTH       = 10
) (
  input  logic               vga_clock,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [Y_WIDTH-1:0] mario_y,
  input  logic               enemy_contact,
  input  logic               stomp,
  input  logic signed [31:0] lives,
  output logic               kill,
  output logic               freeze,
  output logic               respawn,
  output logic               invincible,
  output logic               game_over
);

  typedef enum logic [2:0] {
    ALIVE     = 3'd0,
    DYING     = 3'd1,
    RESPAWN   = 3'd2,
    INVULN    = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam logic [15:0]        DEATH_CNT  = 16'(DEATH_FRAMES);
  localparam logic [15:0]        INVULN_CNT = 16'(INVULN_FRAMES);
  localparam logic [Y_WIDTH-1:0] FLOOR_LIM  = Y_WIDTH'(FLOOR_Y);

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] frame_cnt_r;
  logic        cnt_clr_s;
  logic        cnt_inc_s;
  logic        hit_s;
  logic        kill_r;
  logic        freeze_r;
  logic        respawn_r;
  logic        invincible_r;
  logic        game_over_r;

  // A stomp cancels enemy contact; falling below the floor always kills.
  assign hit_s = (enemy_contact & ~stomp) | (mario_y > FLOOR_LIM);

  // Next-state and frame counter control.
  always_comb begin
    next_state_s = state_r;
    cnt_clr_s    = 1'b0;
    cnt_inc_s    = 1'b0;
    case (state_r)
      ALIVE: begin
        if (hit_s) begin
          next_state_s = DYING;
          cnt_clr_s    = 1'b1;
        end else begin
          next_state_s = ALIVE;
        end
      end
      DYING: begin
        if (frame_cnt_r == DEATH_CNT) begin
          if (lives == 32'sd0) begin
            next_state_s = GAME_OVER;
          end else begin
            next_state_s = RESPAWN;
          end
        end else if (frame_tick) begin
          cnt_inc_s = 1'b1;
        end else begin
          next_state_s = DYING;
        end
      end
      RESPAWN: begin
        next_state_s = INVULN;
        cnt_clr_s    = 1'b1;
      end
      INVULN: begin
        if (frame_cnt_r == INVULN_CNT) begin
          next_state_s = ALIVE;
        end else if (frame_tick) begin
          cnt_inc_s = 1'b1;
        end else begin
          next_state_s = INVULN;
        end
      end
      GAME_OVER: begin
        next_state_s = GAME_OVER;
      end
      default: begin
        next_state_s = ALIVE;
        cnt_clr_s    = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      state_r <= ALIVE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Frame counter; saturates rather than wrapping.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      frame_cnt_r <= 16'd0;
    end else if (cnt_clr_s) begin
      frame_cnt_r <= 16'd0;
    end else if (cnt_inc_s && (frame_cnt_r != 16'hFFFF)) begin
      frame_cnt_r <= frame_cnt_r + 16'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  // Registered Moore outputs, one cycle behind the state register.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      kill_r       <= 1'b0;
      freeze_r     <= 1'b0;
      respawn_r    <= 1'b0;
      invincible_r <= 1'b0;
      game_over_r  <= 1'b0;
    end else begin
      kill_r       <= (state_r == DYING);
      freeze_r     <= (state_r == DYING) || (state_r == RESPAWN) || (state_r == GAME_OVER);
      respawn_r    <= (state_r == RESPAWN);
      invincible_r <= (state_r == INVULN);
      game_over_r  <= (state_r == GAME_OVER);
    end
  end

  assign kill       = kill_r;
  assign freeze     = freeze_r;
  assign respawn    = respawn_r;
  assign invincible = invincible_r;
  assign game_over  = game_over_r;

endmodule

// File: tb/tb_death_sequencer.sv
// Bench for death_sequencer: a reference model queues expected output changes,
// a monitor pops and compares them whenever the DUT outputs change.
module tb_death_sequencer;

  localparam int DF    = 4;
  localparam int INVF  = 8;
  localparam int FLOOR = 470;

  logic              vga_clock = 1'b0;
  logic              reset = 1'b0;
  logic              frame_tick = 1'b0;
  logic [9:0]        mario_y = 10'd100;
  logic              enemy_contact = 1'b0;
  logic              stomp = 1'b0;
  logic signed [31:0] lives = 32'sd3;
  logic              kill, freeze, respawn, invincible, game_over;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  vec;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  // model state
  int          m_mode;
  int          m_left;
  logic [4:0]  m_last;
  logic [4:0]  m_next;
  bit          m_hit;
  exp_t        m_e;

  // monitor state
  logic [4:0]  mon_last;
  logic [4:0]  mon_v;
  exp_t        mon_e;

  death_sequencer #(
    .DEATH_FRAMES (DF),
    .INVULN_FRAMES(INVF),
    .FLOOR_Y      (FLOOR),
    .Y_WIDTH      (10)
  ) dut (
    .vga_clock    (vga_clock),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .mario_y      (mario_y),
    .enemy_contact(enemy_contact),
    .stomp        (stomp),
    .lives        (lives),
    .kill         (kill),
    .freeze       (freeze),
    .respawn      (respawn),
    .invincible   (invincible),
    .game_over    (game_over)
  );

  always #5 vga_clock = ~vga_clock;

  always @(posedge vga_clock) cyc <= cyc + 1;

  // frame_tick every 10 cycles, driven on the falling edge
  initial begin
    int d;
    d = 0;
    forever begin
      @(negedge vga_clock);
      d = (d == 9) ? 0 : d + 1;
      frame_tick = (d == 0);
    end
  end

  // {kill, freeze, respawn, invincible, game_over} for each life phase
  function automatic logic [4:0] phase_outputs(input int m);
    case (m)
      1:       return 5'b11000;  // dying
      2:       return 5'b01100;  // respawn
      3:       return 5'b00010;  // invulnerable
      4:       return 5'b01001;  // game over
      default: return 5'b00000;  // alive
    endcase
  endfunction

  // Reference model: phase plus frames remaining; outputs show the phase held before each edge.
  initial begin
    m_mode = 0;
    m_left = 0;
    m_last = 5'b0;
    forever begin
      @(posedge vga_clock or negedge reset);
      if (!reset) begin
        m_mode = 0;
        m_left = 0;
        m_last = 5'b0;
        exp_q.delete();
      end else begin
        m_next = phase_outputs(m_mode);
        m_hit  = (enemy_contact && !stomp) || (mario_y > FLOOR);
        case (m_mode)
          0: if (m_hit) begin m_mode = 1; m_left = DF; end
          1: begin
            if (m_left == 0) m_mode = (lives == 0) ? 4 : 2;
            else if (frame_tick) m_left = m_left - 1;
          end
          2: begin m_mode = 3; m_left = INVF; end
          3: begin
            if (m_left == 0) m_mode = 0;
            else if (frame_tick) m_left = m_left - 1;
          end
          default: ;
        endcase
        if (m_next != m_last) begin
          m_e.cyc = cyc + 1;
          m_e.vec = m_next;
          exp_q.push_back(m_e);
          m_last = m_next;
        end
      end
    end
  end

  // Monitor: compares every DUT output change against the queued expectation.
  initial begin
    mon_last = 5'b0;
    forever begin
      @(posedge vga_clock or negedge reset);
      if (!reset) begin
        mon_last = 5'b0;
      end else begin
        #1;
        mon_v = {kill, freeze, respawn, invincible, game_over};
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          mon_e = exp_q.pop_front();
          total++;
          bad++;
          $display("FAIL missed_change: got %b at cycle %0d, required %b at cycle %0d",
                   mon_v, cyc, mon_e.vec, mon_e.cyc);
        end
        if (mon_v !== mon_last) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_change: got %b at cycle %0d, required %b", mon_v, cyc, mon_last);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.vec !== mon_v || mon_e.cyc != cyc) begin
              bad++;
              $display("FAIL out_change: got %b at cycle %0d, required %b at cycle %0d",
                       mon_v, cyc, mon_e.vec, mon_e.cyc);
            end
          end
          mon_last = mon_v;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge vga_clock);
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return kill;
      1:       return invincible;
      default: return game_over;
    endcase
  endfunction

  // Bounded wait for an output to reach a level; an expired bound is a failure.
  task automatic wait_level(input int which, input logic lvl, input int maxc, input string nm);
    int k;
    k = 0;
    while (pick(which) !== lvl && k < maxc) begin
      @(negedge vga_clock);
      k++;
    end
    total++;
    if (pick(which) !== lvl) begin
      bad++;
      $display("FAIL %s: got %b after %0d cycles, required %b", nm, pick(which), maxc, lvl);
    end
  endtask

  task automatic check_outputs(input logic [4:0] want, input string nm);
    total++;
    if ({kill, freeze, respawn, invincible, game_over} !== want) begin
      bad++;
      $display("FAIL %s: got %b, required %b", nm,
               {kill, freeze, respawn, invincible, game_over}, want);
    end
  endtask

  // Reset pulse asserted between clock edges; outputs must clear at once.
  task automatic async_reset_pulse(input string nm);
    #2 reset = 1'b0;
    #1 check_outputs(5'b00000, nm);
    @(negedge vga_clock);
    reset = 1'b1;
  endtask

  task automatic pulse_hit();
    enemy_contact = 1'b1;
    step(1);
    enemy_contact = 1'b0;
  endtask

  initial begin
    int t;
    int k;
    step(3);
    check_outputs(5'b00000, "reset_state");
    reset = 1'b1;
    step(2);

    // side hit with lives left: full death, respawn, invulnerability
    lives = 32'sd3;
    pulse_hit();
    step(150);

    // stomp overrides contact
    enemy_contact = 1'b1;
    stomp = 1'b1;
    step(20);
    enemy_contact = 1'b0;
    stomp = 1'b0;
    step(5);

    // floor line: 470 is safe, 471 kills
    mario_y = 10'd470;
    step(50);
    check_outputs(5'b00000, "floor_470_safe");
    mario_y = 10'd471;
    step(1);
    mario_y = 10'd100;
    step(150);

    // hits masked during invulnerability, honoured once alive again
    pulse_hit();
    wait_level(1, 1'b1, 100, "invuln_start");
    enemy_contact = 1'b1;
    mario_y = 10'd480;
    step(3);
    check_outputs(5'b00010, "invuln_masks_hits");
    wait_level(1, 1'b0, 120, "invuln_end");
    step(1);
    enemy_contact = 1'b0;
    mario_y = 10'd100;
    wait_level(0, 1'b1, 5, "kill_after_invuln");
    step(150);

    // reset mid-death after two frame ticks, then a full death again
    pulse_hit();
    wait_level(0, 1'b1, 5, "kill_rise");
    t = 0;
    k = 0;
    while (t < 2 && k < 60) begin
      @(posedge vga_clock);
      if (frame_tick) t++;
      k++;
    end
    @(negedge vga_clock);
    async_reset_pulse("reset_mid_dying");
    step(2);
    pulse_hit();
    step(150);

    // game over when lives reach zero during the death
    lives = 32'sd1;
    pulse_hit();
    wait_level(0, 1'b1, 5, "kill_rise_go");
    step(2);
    lives = 32'sd0;
    wait_level(2, 1'b1, 80, "game_over_rise");
    enemy_contact = 1'b1;
    mario_y = 10'd480;
    step(20);
    enemy_contact = 1'b0;
    mario_y = 10'd100;
    check_outputs(5'b01001, "game_over_sticky");
    async_reset_pulse("reset_from_game_over");
    lives = 32'sd3;
    step(2);

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      enemy_contact = ($urandom_range(0, 15) == 0);
      stomp = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 63) == 0) mario_y = 10'($urandom_range(471, 520));
      else mario_y = 10'($urandom_range(0, 470));
      if ($urandom_range(0, 199) == 0) lives = $signed(32'($urandom_range(0, 3)));
      if ((i % 500) == 499 || $urandom_range(0, 999) == 0) begin
        async_reset_pulse("reset_random");
      end else begin
        step(1);
      end
    end
    enemy_contact = 1'b0;
    stomp = 1'b0;
    mario_y = 10'd100;
    step(5);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_expectations: got %0d left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/death_sequencer.md
Name: death_sequencer

Overview:
- Sits directly upstream of the lives counter and drives its kill input.
- Detects Mario's death from two causes: side contact with an enemy, or falling below the floor line.
- Holds kill high for a timed death animation, then either requests a respawn followed by an invulnerability window, or latches game over.
- Also freezes game physics while Mario is dying.

Parameters:
- DEATH_FRAMES, 60, frames the death animation lasts, with kill held high; must be >= 1.
- INVULN_FRAMES, 120, frames of invulnerability after a respawn; must be >= 1.
- FLOOR_Y, 470, a mario_y value strictly greater than this counts as falling off the screen.
- Y_WIDTH, 10, width of mario_y.

Ports:
- vga_clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- frame_tick  input  1  one-cycle pulse per video frame.
- mario_y  input  Y_WIDTH  Mario's top-edge y coordinate, unsigned.
- enemy_contact  input  1  Mario overlaps an enemy this cycle (level).
- stomp  input  1  the overlap is a stomp from above (level); suppresses death.
- lives  input  32  remaining lives from the lives counter (signed int).
- kill  output  1  death in progress; connects to the lives counter kill input.
- freeze  output  1  halts physics and enemy motion.
- respawn  output  1  one-cycle pulse telling the position logic to reload Mario's start position.
- invincible  output  1  hits are ignored; drives the sprite blink.
- game_over  output  1  sticky until reset.

Behaviour:
- Reset (async, reset=0):
  - state=ALIVE and frame_cnt=0.
  - kill, freeze, respawn, invincible and game_over are all 0.
  - All outputs are registered and Moore-decoded from state.
- hit = (enemy_contact & ~stomp) | (mario_y > FLOOR_Y). stomp overrides enemy_contact when both are high in the same cycle. The fall condition is not maskable.
- ALIVE:
  - If hit is sampled high, go to DYING next cycle and clear frame_cnt.
  - Otherwise stay in ALIVE.
- DYING:
  - kill=1 and freeze=1.
  - frame_cnt increments on each frame_tick. A frame_tick in the same cycle as entry into DYING is not counted.
  - When frame_cnt reaches DEATH_FRAMES (compared on the cycle after the final tick):
    - if lives == 0, go to GAME_OVER;
    - otherwise go to RESPAWN.
  - hit is ignored in this state.
- Lives-counter timing: the lives counter decrements 2 cycles after kill rises, and needs kill to fall before it will accept the next death. The DYING dwell of at least one frame therefore guarantees lives is settled before it is compared.
- RESPAWN:
  - Lasts exactly one cycle.
  - respawn=1, freeze=1, kill=0.
  - Next state is INVULN with frame_cnt cleared.
- INVULN:
  - invincible=1.
  - hits are ignored, including falls. The position logic has already reset Mario's y.
  - Counts INVULN_FRAMES frame_ticks, then returns to ALIVE with invincible=0.
- GAME_OVER:
  - freeze=1 and game_over=1; kill=0.
  - Terminal state; only reset exits it.
- Frame counter:
  - 16 bits, unsigned.
  - Saturates at 16'hFFFF, which is unreachable with legal parameters.
- Reset in any state, including mid-DYING, returns immediately to the reset values. The lives counter is reset by the same signal.
- Latency: hit sampled at edge N gives kill=1 after edge N+1.

Test Plan:
- Test parameters for all scenarios: DEATH_FRAMES=4, INVULN_FRAMES=8, FLOOR_Y=470, frame_tick every 10 cycles.
- Side hit, lives=3:
  - enemy_contact=1, stomp=0 for 1 cycle → kill=1 and freeze=1 from the next cycle.
  - kill falls after the 4th frame_tick.
  - Then respawn=1 for exactly 1 cycle.
  - Then invincible=1 for 8 frames, then state ALIVE.
- Stomp override: enemy_contact=1 and stomp=1 together for 20 cycles → kill, freeze and respawn stay 0 throughout.
- Fall: mario_y=471 → kill rises. Control case: mario_y=470 for 50 cycles → no kill.
- Game over: model lives dropping to 0 during DYING → after 4 frames game_over=1, freeze=1, kill=0, and respawn never pulses. Further hits have no effect until reset.
- Invulnerability masking: during INVULN apply enemy_contact=1 and mario_y=480 → kill stays 0. A hit applied 1 cycle after returning to ALIVE → kill=1.
- Async reset mid-DYING after 2 frame_ticks: assert reset=0 between clock edges → all outputs 0 immediately. After release, state is ALIVE and the next hit needs the full 4 frames again.
